// File: rtl/icache_axi_refill_buffer_pkg.sv
// Shared constants and the refill queue entry type for the instruction-cache AXI refill path.
package ariane_pkg;
  localparam int unsigned ICACHE_LINE_WIDTH = 128;
endpackage

package wt_cache_pkg;
  localparam int unsigned ICACHE_REFILL_ID_WIDTH = 4;

  typedef struct packed {
    logic [ariane_pkg::ICACHE_LINE_WIDTH-1:0] data;
    logic [ICACHE_REFILL_ID_WIDTH-1:0]        id;
    logic                                     nc;
    logic                                     err;
  } icache_refill_line_t;
endpackage

// File: rtl/icache_axi_refill_buffer_fifo_v3.sv
// Small synchronous FIFO with the common_cells fifo_v3 interface (flush, full/empty, optional fall-through).
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DEPTH        = 8,
  parameter type         dtype        = logic
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  output logic full_o,
  output logic empty_o,
  input  dtype data_i,
  input  logic push_i,
  output dtype data_o,
  input  logic pop_i
);
  localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AddrW:0]   cnt_q;
  dtype             mem_q [DEPTH];
  logic             do_push, do_pop, bypass;

  function automatic logic [AddrW-1:0] ptr_inc(input logic [AddrW-1:0] p);
    return (p == AddrW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == (AddrW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0) & ~(FALL_THROUGH & push_i);
  assign data_o  = (FALL_THROUGH && cnt_q == '0) ? data_i : mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  // A fall-through word popped while the FIFO is empty never touches storage.
  assign bypass  = FALL_THROUGH && (cnt_q == '0) && do_push && do_pop;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (!bypass) begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (do_push && !do_pop)      cnt_q <= cnt_q + 1'b1;
      else if (!do_push && do_pop) cnt_q <= cnt_q - 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; the occupancy count alone decides what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push && !bypass && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end
endmodule

// File: rtl/icache_axi_refill_buffer.sv
// Assembles 64-bit AXI R beats into cache lines and queues completed lines in order.
module icache_axi_refill_buffer
  import wt_cache_pkg::*;
#(
  parameter int unsigned LineWidth = ariane_pkg::ICACHE_LINE_WIDTH,
  parameter int unsigned IdWidth   = ICACHE_REFILL_ID_WIDTH,
  parameter int unsigned Depth     = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic                 beat_valid_i,
  output logic                 beat_rdy_o,
  input  logic [63:0]          beat_data_i,
  input  logic                 beat_last_i,
  input  logic [IdWidth-1:0]   beat_id_i,
  input  logic                 beat_err_i,
  output logic                 line_valid_o,
  input  logic                 line_ready_i,
  output logic [LineWidth-1:0] line_data_o,
  output logic [IdWidth-1:0]   line_id_o,
  output logic                 line_nc_o,
  output logic                 line_err_o,
  output logic                 busy_o
);
  localparam int unsigned W    = LineWidth / 64;
  localparam int unsigned CntW = $clog2(W + 1);

  logic [W-1:0][63:0]  words_q, words_d, line_words;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [IdWidth-1:0]  id_q, id_d;
  logic                err_q, err_d;
  logic                accept, first, beat_bad, q_full, q_empty, push, pop;
  icache_refill_line_t push_line, head_line;

  assign beat_rdy_o = ~q_full;
  assign accept     = beat_valid_i & beat_rdy_o;
  assign first      = (cnt_q == '0);
  assign push       = accept & beat_last_i & ~clr_i;
  assign pop        = line_valid_o & line_ready_i & ~clr_i;

  always_comb begin
    words_d    = words_q;
    cnt_d      = cnt_q;
    id_d       = id_q;
    err_d      = err_q;
    line_words = words_q;
    for (int k = 0; k < W; k++) begin
      if (cnt_q == CntW'(k)) line_words[k] = beat_data_i;
    end
    // Overflow beats, mismatched IDs and bus errors all poison the line.
    beat_bad = err_q | beat_err_i | (cnt_q == CntW'(W)) | (!first && beat_id_i != id_q);

    push_line      = '0;
    push_line.data = line_words;
    push_line.id   = first ? beat_id_i : id_q;
    push_line.nc   = first;
    push_line.err  = beat_bad | (!first && cnt_q < CntW'(W - 1));

    if (accept) begin
      if (beat_last_i) begin
        words_d = '0;
        cnt_d   = '0;
        err_d   = 1'b0;
      end else begin
        words_d = line_words;
        cnt_d   = (cnt_q == CntW'(W)) ? cnt_q : cnt_q + 1'b1;
        id_d    = push_line.id;
        err_d   = beat_bad;
      end
    end
    if (clr_i) begin
      words_d = '0;
      cnt_d   = '0;
      err_d   = 1'b0;
    end
  end

  // NOTE: sequential state updates use non-blocking assignments only; next-state is built above.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      words_q <= '0;
      cnt_q   <= '0;
      id_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      words_q <= words_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      err_q   <= err_d;
    end
  end

  fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DEPTH        (Depth),
    .dtype        (icache_refill_line_t)
  ) i_line_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (clr_i),
    .full_o  (q_full),
    .empty_o (q_empty),
    .data_i  (push_line),
    .push_i  (push),
    .data_o  (head_line),
    .pop_i   (pop)
  );

  assign line_valid_o = ~q_empty;
  assign line_data_o  = head_line.data;
  assign line_id_o    = head_line.id;
  assign line_nc_o    = head_line.nc;
  assign line_err_o   = head_line.err;
  assign busy_o       = (cnt_q != '0) | ~q_empty;
endmodule

// File: tb/tb_icache_axi_refill_buffer.sv
// Bench for icache_axi_refill_buffer: a burst-level reference model plus directed line checks.
module tb_icache_axi_refill_buffer;
  localparam int LW    = 128;
  localparam int IW    = 4;
  localparam int DEPTH = 2;
  localparam int W     = LW / 64;

  logic          clk = 1'b0, rst_n = 1'b0, clr = 1'b0;
  logic          bv = 1'b0, bl = 1'b0, be = 1'b0, lr = 1'b0;
  logic [63:0]   bd = '0;
  logic [IW-1:0] bid = '0;
  logic          beat_rdy, line_valid, line_nc, line_err, busy;
  logic [LW-1:0] line_data;
  logic [IW-1:0] line_id;

  int checks = 0;
  int errors = 0;

  icache_axi_refill_buffer #(.LineWidth(LW), .IdWidth(IW), .Depth(DEPTH)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .clr_i        (clr),
    .beat_valid_i (bv),
    .beat_rdy_o   (beat_rdy),
    .beat_data_i  (bd),
    .beat_last_i  (bl),
    .beat_id_i    (bid),
    .beat_err_i   (be),
    .line_valid_o (line_valid),
    .line_ready_i (lr),
    .line_data_o  (line_data),
    .line_id_o    (line_id),
    .line_nc_o    (line_nc),
    .line_err_o   (line_err),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: beats of the open burst and the completed-line queue.
  typedef struct {logic [63:0] d; logic [IW-1:0] id; logic e;} beat_t;
  typedef struct {logic [LW-1:0] d; logic [IW-1:0] id; logic nc; logic err;} line_t;
  beat_t mb[$];
  line_t mq[$];
  bit    m_acc, m_pop;

  function automatic line_t build_line();
    line_t l;
    int    n = mb.size();
    l.d   = '0;
    l.id  = mb[0].id;
    l.nc  = (n == 1);
    l.err = (n > W) || (n > 1 && n < W);
    for (int i = 0; i < n; i++) begin
      if (mb[i].e || mb[i].id != mb[0].id) l.err = 1'b1;
      if (i < W) l.d[64*i +: 64] = mb[i].d;
    end
    return l;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || clr) begin
      mb.delete();
      mq.delete();
    end else begin
      m_acc = bv && (mq.size() < DEPTH);
      m_pop = lr && (mq.size() > 0);
      if (m_pop) void'(mq.pop_front());
      if (m_acc) begin
        mb.push_back('{bd, bid, be});
        if (bl) begin
          mq.push_back(build_line());
          mb.delete();
        end
      end
    end
  end

  always @(negedge clk) begin
    check("beat_rdy", beat_rdy, mq.size() < DEPTH);
    check("line_valid", line_valid, mq.size() != 0);
    check("busy", busy, (mb.size() != 0) || (mq.size() != 0));
    if (mq.size() != 0) begin
      check("line_data", line_data, mq[0].d);
      check("line_id", line_id, mq[0].id);
      check("line_nc", line_nc, mq[0].nc);
      check("line_err", line_err, mq[0].err);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [63:0] d, input logic [IW-1:0] id, input logic last, input logic err);
    bv = 1'b1; bd = d; bid = id; bl = last; be = err;
    cyc();
    bv = 1'b0; bl = 1'b0; be = 1'b0;
  endtask

  task automatic pop_one();
    lr = 1'b1;
    cyc();
    lr = 1'b0;
  endtask

  initial begin
    repeat (3) cyc();
    check("reset valid", line_valid, 1'b0);
    check("reset busy", busy, 1'b0);
    rst_n = 1'b1;
    cyc();
    check("reset rdy", beat_rdy, 1'b1);

    // Two-beat line
    send(64'hA, 4'd3, 1'b0, 1'b0);
    send(64'hB, 4'd3, 1'b1, 1'b0);
    check("t1 valid", line_valid, 1'b1);
    check("t1 data", line_data, 128'h000000000000000B_000000000000000A);
    check("t1 id", line_id, 4'd3);
    check("t1 nc", line_nc, 1'b0);
    check("t1 err", line_err, 1'b0);
    pop_one();
    check("t1 drained", line_valid, 1'b0);

    // Single-beat bypass line
    send(64'h55, 4'd5, 1'b1, 1'b0);
    check("t2 data", line_data, 128'h55);
    check("t2 nc", line_nc, 1'b1);
    check("t2 err", line_err, 1'b0);
    pop_one();

    // Overlong burst and ID mismatch
    send(64'h1, 4'd0, 1'b0, 1'b0);
    send(64'h2, 4'd0, 1'b0, 1'b0);
    send(64'h3, 4'd0, 1'b1, 1'b0);
    check("t3 data", line_data, 128'h0000000000000002_0000000000000001);
    check("t3 err", line_err, 1'b1);
    pop_one();
    send(64'h4, 4'd1, 1'b0, 1'b0);
    send(64'h5, 4'd2, 1'b1, 1'b0);
    check("t3 id err", line_err, 1'b1);
    check("t3 id", line_id, 4'd1);
    pop_one();
    send(64'h6, 4'd1, 1'b0, 1'b1);
    send(64'h7, 4'd1, 1'b1, 1'b0);
    check("t3 resp err", line_err, 1'b1);
    pop_one();

    // Queue fills, then frees one slot
    send(64'h10, 4'd1, 1'b1, 1'b0);
    send(64'h20, 4'd2, 1'b1, 1'b0);
    check("t4 full rdy", beat_rdy, 1'b0);
    check("t4 head", line_data, 128'h10);
    pop_one();
    check("t4 rdy back", beat_rdy, 1'b1);
    check("t4 order", line_data, 128'h20);
    pop_one();

    // Simultaneous push and pop with one line queued
    send(64'h30, 4'd1, 1'b1, 1'b0);
    lr = 1'b1;
    send(64'h40, 4'd1, 1'b1, 1'b0);
    lr = 1'b0;
    check("t5 valid", line_valid, 1'b1);
    check("t5 head", line_data, 128'h40);
    pop_one();
    check("t5 one left", line_valid, 1'b0);

    // Clear mid-burst, and clear overriding a last beat
    send(64'h7, 4'd2, 1'b0, 1'b0);
    check("t6 busy mid", busy, 1'b1);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    check("t6 clr busy", busy, 1'b0);
    send(64'h8, 4'd2, 1'b0, 1'b0);
    send(64'h9, 4'd2, 1'b1, 1'b0);
    check("t6 data", line_data, 128'h0000000000000009_0000000000000008);
    check("t6 err", line_err, 1'b0);
    clr = 1'b1;
    send(64'h77, 4'd2, 1'b1, 1'b0);
    clr = 1'b0;
    check("t6 clr wins", line_valid, 1'b0);

    // Reset mid-burst
    send(64'hC, 4'd6, 1'b0, 1'b0);
    rst_n = 1'b0;
    #2;
    check("t7 rst busy", busy, 1'b0);
    rst_n = 1'b1;
    cyc();
    send(64'hD, 4'd6, 1'b0, 1'b0);
    send(64'hE, 4'd6, 1'b1, 1'b0);
    check("t7 data", line_data, 128'h000000000000000E_000000000000000D);
    check("t7 err", line_err, 1'b0);
    pop_one();

    // Mixed traffic against the model
    for (int i = 0; i < 400; i++) begin
      bv  = 1'($urandom_range(0, 1));
      bd  = {$urandom, $urandom};
      bid = IW'($urandom_range(1, 2));
      bl  = ($urandom_range(0, 2) == 0);
      be  = ($urandom_range(0, 15) == 0);
      lr  = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 40) == 0);
      cyc();
    end
    bv = 1'b0; bl = 1'b0; be = 1'b0; clr = 1'b0; lr = 1'b1;
    repeat (4) cyc();
    check("end drained", line_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
